// File: rtl/data_bus_router_pkg.sv
// Shared types and helpers for the DLX data-port router.
package data_bus_router_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        ErrNone,
        ErrDecode,
        ErrTimeout
    } err_e;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Width of the BUSY-cycle counter; it must hold TIMEOUT_CYCLES-1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/data_bus_router_if.sv
// Processor data port plus the shared slave channel. The slave modport is the router's view;
// the master modport is the environment (processor and peripherals).
interface data_bus_router_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = 4,
    parameter int unsigned NUM_SLAVES = 4
);
    logic                             m_rd_en;
    logic                             m_wr_en;
    logic [ADDR_WIDTH-1:0]            m_addr;
    logic [DATA_WIDTH-1:0]            m_wr_data;
    logic [BE_WIDTH-1:0]              m_be;
    logic [DATA_WIDTH-1:0]            m_rd_data;
    logic                             m_stall;
    logic                             m_err;

    logic [NUM_SLAVES-1:0]            slv_req;
    logic                             slv_we;
    logic [ADDR_WIDTH-1:0]            slv_addr;
    logic [DATA_WIDTH-1:0]            slv_wr_data;
    logic [BE_WIDTH-1:0]              slv_be;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rd_data;
    logic [NUM_SLAVES-1:0]            slv_ack;

    modport master (
        output m_rd_en, m_wr_en, m_addr, m_wr_data, m_be,
        input  m_rd_data, m_stall, m_err,
        input  slv_req, slv_we, slv_addr, slv_wr_data, slv_be,
        output slv_rd_data, slv_ack
    );

    modport slave (
        input  m_rd_en, m_wr_en, m_addr, m_wr_data, m_be,
        output m_rd_data, m_stall, m_err,
        output slv_req, slv_we, slv_addr, slv_wr_data, slv_be,
        input  slv_rd_data, slv_ack
    );

endinterface

// File: rtl/data_bus_router_bus_addr_decoder.sv
// Slave-select decode: index from the address select field, valid when it names a present
// slave and the request is not simultaneously a read and a write.
module bus_addr_decoder #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SEL_BITS   = 2
) (
    input  logic [SEL_BITS-1:0] sel_field,
    input  logic                rd_en,
    input  logic                wr_en,
    output logic [SEL_BITS-1:0] idx,
    output logic                valid
);

    always_comb begin
        idx   = sel_field;
        valid = (32'(sel_field) < NUM_SLAVES) && !(rd_en && wr_en);
    end

endmodule

// File: rtl/data_bus_router.sv
// Routes DLX data accesses to one of NUM_SLAVES targets, stalls the master until the selected
// slave acks, and reports decode/timeout errors with a saturating count.
module data_bus_router
    import data_bus_router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned BE_WIDTH       = 4,
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned SEL_LSB        = 28,
    parameter int unsigned SEL_BITS       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    data_bus_router_if.slave  bus,
    output logic [7:0]        err_cnt
);

    localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES);

    state_e                state_q;
    logic [NUM_SLAVES-1:0] req_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [CntW-1:0]       cnt_q;
    logic [7:0]            err_cnt_q;

    logic                  req_seen;
    logic [SEL_BITS-1:0]   dec_idx;
    logic                  dec_valid;
    logic                  ack_sel;
    logic [DATA_WIDTH-1:0] rd_sel;
    logic                  timeout;
    err_e                  err_code;

    assign req_seen = bus.m_rd_en || bus.m_wr_en;
    assign timeout  = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    bus_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_BITS   (SEL_BITS)
    ) u_decoder (
        .sel_field (bus.m_addr[SEL_LSB +: SEL_BITS]),
        .rd_en     (bus.m_rd_en),
        .wr_en     (bus.m_wr_en),
        .idx       (dec_idx),
        .valid     (dec_valid)
    );

    // The one-hot request selects the ack and read slice, so other slaves' acks are ignored.
    always_comb begin
        ack_sel = 1'b0;
        rd_sel  = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (req_q[i]) begin
                ack_sel = bus.slv_ack[i];
                rd_sel  = bus.slv_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Ack has priority over a coincident timeout.
    always_comb begin
        err_code = ErrNone;
        if (state_q == StIdle && req_seen && !dec_valid) begin
            err_code = ErrDecode;
        end else if (state_q == StBusy && !ack_sel && timeout) begin
            err_code = ErrTimeout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            req_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (err_code != ErrNone && err_cnt_q != ERR_CNT_MAX) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (req_seen) begin
                        we_q    <= bus.m_wr_en;
                        addr_q  <= bus.m_addr;
                        wdata_q <= bus.m_wr_data;
                        be_q    <= bus.m_be;
                        cnt_q   <= '0;
                        if (dec_valid) begin
                            req_q   <= NUM_SLAVES'(1) << dec_idx;
                            state_q <= StBusy;
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state_q <= StResp;
                        end
                    end
                end
                StBusy: begin
                    if (ack_sel) begin
                        req_q   <= '0;
                        rdata_q <= we_q ? '0 : rd_sel;
                        state_q <= StResp;
                    end else if (timeout) begin
                        req_q   <= '0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.m_stall     = (state_q == StBusy) || (state_q == StIdle && req_seen);
    assign bus.m_rd_data   = rdata_q;
    assign bus.m_err       = err_q;
    assign bus.slv_req     = req_q;
    assign bus.slv_we      = we_q;
    assign bus.slv_addr    = addr_q;
    assign bus.slv_wr_data = wdata_q;
    assign bus.slv_be      = be_q;
    assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_data_bus_router.sv
// Directed bench for data_bus_router with three slaves and an 8-cycle timeout.
module tb_data_bus_router;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned NS = 3;
    localparam int unsigned SL = 28;
    localparam int unsigned SB = 2;
    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  err_cnt;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned stall_cycles;
    int unsigned req_cycles;

    data_bus_router_if #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BE_WIDTH   (BW),
        .NUM_SLAVES (NS)
    ) bus ();

    data_bus_router #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .BE_WIDTH       (BW),
        .NUM_SLAVES     (NS),
        .SEL_LSB        (SL),
        .SEL_BITS       (SB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.m_rd_en     = 1'b0;
        bus.m_wr_en     = 1'b0;
        bus.m_addr      = '0;
        bus.m_wr_data   = '0;
        bus.m_be        = '0;
        bus.slv_rd_data = '0;
        bus.slv_ack     = '0;
        #12;
        chk("rst_stall", 32'(bus.m_stall), 32'd0);
        chk("rst_req", 32'(bus.slv_req), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_rd_data", bus.m_rd_data, 32'd0);
        chk("rst_err", 32'(bus.m_err), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Read slave 1, ack two cycles after slv_req rises.
        bus.m_rd_en = 1'b1;
        bus.m_addr  = 32'h1000_0010;
        #1;
        chk("t1_stall_c0", 32'(bus.m_stall), 32'd1);
        stall_cycles = 32'(bus.m_stall);
        step(); #1;
        chk("t1_req", 32'(bus.slv_req), 32'b010);
        chk("t1_we", 32'(bus.slv_we), 32'd0);
        chk("t1_addr", bus.slv_addr, 32'h1000_0010);
        stall_cycles += 32'(bus.m_stall);
        step(); #1;
        stall_cycles += 32'(bus.m_stall);
        step();
        bus.slv_ack            = 3'b010;
        bus.slv_rd_data[32 +: 32] = 32'hCAFE_F00D;
        #1;
        stall_cycles += 32'(bus.m_stall);
        step();
        bus.slv_ack = '0;
        #1;
        chk("t1_resp_stall", 32'(bus.m_stall), 32'd0);
        chk("t1_rd_data", bus.m_rd_data, 32'hCAFE_F00D);
        chk("t1_err", 32'(bus.m_err), 32'd0);
        chk("t1_req_clr", 32'(bus.slv_req), 32'd0);
        chk("t1_stall_cycles", stall_cycles, 32'd4);
        step();
        bus.m_rd_en = 1'b0;
        #1;
        chk("t1_idle_stall", 32'(bus.m_stall), 32'd0);
        step(); #1;
        chk("t1_resp_req_ignored", 32'(bus.slv_req), 32'd0);
        chk("t1_rd_hold", bus.m_rd_data, 32'hCAFE_F00D);

        // Write slave 0 with immediate ack.
        step();
        bus.m_wr_en   = 1'b1;
        bus.m_addr    = 32'h0000_0040;
        bus.m_wr_data = 32'h1234_5678;
        bus.m_be      = 4'b0011;
        #1;
        chk("t2_stall_c0", 32'(bus.m_stall), 32'd1);
        step();
        bus.slv_ack = 3'b001;
        #1;
        chk("t2_req", 32'(bus.slv_req), 32'b001);
        chk("t2_we", 32'(bus.slv_we), 32'd1);
        chk("t2_be", 32'(bus.slv_be), 32'b0011);
        chk("t2_wr_data", bus.slv_wr_data, 32'h1234_5678);
        step();
        bus.slv_ack = '0;
        #1;
        chk("t2_resp_c2", 32'(bus.m_stall), 32'd0);
        chk("t2_err", 32'(bus.m_err), 32'd0);
        chk("t2_rd_zero", bus.m_rd_data, 32'd0);
        step();
        bus.m_wr_en = 1'b0;

        // Select field 3 with only three slaves: decode error.
        step();
        bus.m_rd_en = 1'b1;
        bus.m_addr  = 32'h3000_0000;
        #1;
        chk("t3_stall_c0", 32'(bus.m_stall), 32'd1);
        step(); #1;
        chk("t3_resp_stall", 32'(bus.m_stall), 32'd0);
        chk("t3_err", 32'(bus.m_err), 32'd1);
        chk("t3_no_req", 32'(bus.slv_req), 32'd0);
        chk("t3_err_cnt", 32'(err_cnt), 32'd1);
        step();
        bus.m_rd_en = 1'b0;
        #1;
        chk("t3_err_pulse", 32'(bus.m_err), 32'd0);

        // Slave 2 never acks: timeout after 8 BUSY cycles.
        step();
        bus.m_rd_en = 1'b1;
        bus.m_addr  = 32'h2000_0000;
        bus.slv_rd_data[64 +: 32] = 32'hDEAD_BEEF;
        step(); #1;
        req_cycles = 0;
        for (int n = 0; n < 20 && bus.m_stall; n++) begin
            if (bus.slv_req == 3'b100) req_cycles++;
            step(); #1;
        end
        chk("t4_req_cycles", req_cycles, 32'd8);
        chk("t4_resp_stall", 32'(bus.m_stall), 32'd0);
        chk("t4_err", 32'(bus.m_err), 32'd1);
        chk("t4_rd_zero", bus.m_rd_data, 32'd0);
        chk("t4_req_clr", 32'(bus.slv_req), 32'd0);
        chk("t4_err_cnt", 32'(err_cnt), 32'd2);
        step();
        bus.m_rd_en = 1'b0;

        // Same access, ack in the final BUSY cycle wins over the timeout.
        step();
        bus.m_rd_en = 1'b1;
        bus.m_addr  = 32'h2000_0000;
        step(); #1;
        repeat (7) step();
        bus.slv_ack = 3'b100;
        #1;
        chk("t4b_stall_c8", 32'(bus.m_stall), 32'd1);
        chk("t4b_req_c8", 32'(bus.slv_req), 32'b100);
        step();
        bus.slv_ack = '0;
        #1;
        chk("t4b_resp_stall", 32'(bus.m_stall), 32'd0);
        chk("t4b_err", 32'(bus.m_err), 32'd0);
        chk("t4b_rd_data", bus.m_rd_data, 32'hDEAD_BEEF);
        chk("t4b_err_cnt", 32'(err_cnt), 32'd2);
        step();
        bus.m_rd_en = 1'b0;

        // Read and write together: decode error even for a present slave.
        step();
        bus.m_rd_en = 1'b1;
        bus.m_wr_en = 1'b1;
        bus.m_addr  = 32'h0000_0000;
        step(); #1;
        chk("t5_resp_stall", 32'(bus.m_stall), 32'd0);
        chk("t5_err", 32'(bus.m_err), 32'd1);
        chk("t5_no_req", 32'(bus.slv_req), 32'd0);
        chk("t5_err_cnt", 32'(err_cnt), 32'd3);
        step();
        bus.m_rd_en = 1'b0;
        bus.m_wr_en = 1'b0;

        // Ack from slave 2 while slave 0 is selected is ignored.
        step();
        bus.m_rd_en = 1'b1;
        bus.m_addr  = 32'h0000_0100;
        step();
        bus.slv_ack = 3'b100;
        bus.slv_rd_data[64 +: 32] = 32'h5555_AAAA;
        #1;
        chk("t5b_req", 32'(bus.slv_req), 32'b001);
        step(); #1;
        chk("t5b_stall_ignored", 32'(bus.m_stall), 32'd1);
        step();
        bus.slv_ack = 3'b001;
        bus.slv_rd_data[0 +: 32] = 32'h0BAD_C0DE;
        #1;
        chk("t5b_stall_c3", 32'(bus.m_stall), 32'd1);
        step();
        bus.slv_ack = '0;
        #1;
        chk("t5b_resp_stall", 32'(bus.m_stall), 32'd0);
        chk("t5b_err", 32'(bus.m_err), 32'd0);
        chk("t5b_rd_data", bus.m_rd_data, 32'h0BAD_C0DE);
        chk("t5b_err_cnt", 32'(err_cnt), 32'd3);
        step();
        bus.m_rd_en = 1'b0;

        // Reset mid-BUSY: request drops without waiting for a clock; counter returns to reset value.
        step();
        bus.m_rd_en = 1'b1;
        bus.m_addr  = 32'h1000_0000;
        step(); #1;
        chk("t6_req_busy", 32'(bus.slv_req), 32'b010);
        chk("t6_err_cnt_pre", 32'(err_cnt), 32'd3);
        rst = 1'b1;
        #1;
        chk("t6_async_req", 32'(bus.slv_req), 32'd0);
        chk("t6_async_err_cnt", 32'(err_cnt), 32'd0);
        step();
        step();
        rst         = 1'b0;
        bus.m_rd_en = 1'b0;
        step(); #1;
        chk("t6_no_resp_err", 32'(bus.m_err), 32'd0);
        chk("t6_idle_stall", 32'(bus.m_stall), 32'd0);
        chk("t6_err_cnt_post", 32'(err_cnt), 32'd0);

        // 300 decode errors saturate the counter at 255.
        for (int i = 0; i < 300; i++) begin
            bus.m_rd_en = 1'b1;
            bus.m_addr  = 32'h3000_0000;
            step();
            bus.m_rd_en = 1'b0;
            step();
            if (i == 253) chk("t6_err_cnt_254", 32'(err_cnt), 32'd254);
            if (i == 254) chk("t6_err_cnt_255", 32'(err_cnt), 32'd255);
        end
        #1;
        chk("t6_err_cnt_sat", 32'(err_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
